// File: rtl/temp_alarm_trigger_pkg.sv
// Shared types and helpers for the temperature alarm trigger.
// Provides the FSM state encoding, the default sample width and the
// millisecond-to-cycle conversion used to size the holdoff/repeat timers.
package alarm_pkg;

   localparam int TEMP_W_DEF = 13;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONFIRM = 3'd1,
      FIRE    = 3'd2,
      ALARM   = 3'd3,
      HOLDOFF = 3'd4
   } state_e;

   // Converts a duration in ms to clock cycles; 64-bit so large products
   // of frequency and duration cannot overflow. Never returns zero.
   function automatic logic [63:0] ms_to_cycles(input logic [63:0] freq,
                                                input logic [63:0] ms);
      logic [63:0] cyc;
      cyc = (freq * ms) / 64'd1000;
      return (cyc == 64'd0) ? 64'd1 : cyc;
   endfunction

endpackage

// File: rtl/temp_alarm_trigger_if.sv
// Sample stream, thresholds and trigger outputs of the temperature alarm.
// master: sensor/configuration side; slave: the alarm trigger itself.
interface temp_alarm_trigger_if
   import alarm_pkg::*;
#(
   parameter int TEMP_W = TEMP_W_DEF
);

   logic                     temp_valid;
   logic signed [TEMP_W-1:0] temp_data;
   logic signed [TEMP_W-1:0] thresh_hi;
   logic signed [TEMP_W-1:0] thresh_lo;
   logic                     control;
   logic                     alarm_active;
   logic [7:0]               fire_count;

   modport master (
      output temp_valid,
      output temp_data,
      output thresh_hi,
      output thresh_lo,
      input  control,
      input  alarm_active,
      input  fire_count
   );

   modport slave (
      input  temp_valid,
      input  temp_data,
      input  thresh_hi,
      input  thresh_lo,
      output control,
      output alarm_active,
      output fire_count
   );

endinterface

// File: rtl/temp_alarm_trigger_ms_timer.sv
// Loadable down-counter used for the holdoff and repeat intervals.
// done is high while the count sits at 1, i.e. in the last cycle of the
// interval; the counter stops at zero.
module ms_timer #(
   parameter int CYC_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CYC_W-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [CYC_W-1:0] count;

   // Load takes priority over counting; counting stops at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == CYC_W'(1));

endmodule

// File: rtl/temp_alarm_trigger.sv
// Temperature alarm trigger: confirms CONFIRM_N consecutive over-threshold
// samples, then issues a single-cycle control pulse to the LED flasher.
// Hysteresis (thresh_hi/thresh_lo) plus a holdoff interval keep noise near
// the threshold from retriggering.
// Optional build macro ALARM_REPEAT_EN: while the alarm persists, re-fire
// the pulse every REPEAT_CYC cycles.
module temp_alarm_trigger
   import alarm_pkg::*;
#(
   parameter int SYS_FREQ   = 100000000,
   parameter int TEMP_W     = TEMP_W_DEF,
   parameter int CONFIRM_N  = 4,
   parameter int HOLDOFF_MS = 1000,
   parameter int REPEAT_MS  = 5000
) (
   input logic                 clk,
   input logic                 reset,
   temp_alarm_trigger_if.slave bus
);

   localparam logic [2:0] S_IDLE    = IDLE;
   localparam logic [2:0] S_CONFIRM = CONFIRM;
   localparam logic [2:0] S_FIRE    = FIRE;
   localparam logic [2:0] S_ALARM   = ALARM;
   localparam logic [2:0] S_HOLDOFF = HOLDOFF;

   localparam logic [63:0] HOLDOFF_CYC = ms_to_cycles(64'(SYS_FREQ), 64'(HOLDOFF_MS));
   localparam logic [63:0] REPEAT_RAW  = ms_to_cycles(64'(SYS_FREQ), 64'(REPEAT_MS));
   // At least two cycles so repeat pulses are never back to back.
   localparam logic [63:0] REPEAT_CYC  = (REPEAT_RAW < 64'd2) ? 64'd2 : REPEAT_RAW;
   localparam int          HOLD_W      = $clog2(HOLDOFF_CYC + 64'd1);
   localparam logic [7:0]  CONFIRM_N8  = 8'(CONFIRM_N);

   logic [2:0]               state;
   logic [2:0]               state_next;
   logic [7:0]               conf_cnt;
   logic [7:0]               conf_next;
   logic [7:0]               conf_inc;
   logic [7:0]               fire_count_r;
   logic signed [TEMP_W-1:0] temp_s;
   logic signed [TEMP_W-1:0] hi_s;
   logic signed [TEMP_W-1:0] lo_s;
   logic                     over;
   logic                     clear;
   logic                     hold_load;
   logic                     hold_done;
   logic                     rep_done;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign temp_s   = bus.temp_data;
   assign hi_s     = bus.thresh_hi;
   assign lo_s     = bus.thresh_lo;
   assign conf_inc = conf_cnt + 8'd1;

   // Signed sample classification; an inverted band falls back to "below hi".
   always_comb begin
      over  = (temp_s >= hi_s);
      clear = (lo_s < hi_s) ? (temp_s <= lo_s) : (temp_s < hi_s);
   end

   // Next-state and confirm-counter decode; samples only act when valid.
   always_comb begin
      state_next = state;
      conf_next  = conf_cnt;
      hold_load  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.temp_valid && over) begin
               conf_next  = 8'd1;
               state_next = (CONFIRM_N == 1) ? S_FIRE : S_CONFIRM;
            end
         end
         S_CONFIRM: begin
            if (bus.temp_valid) begin
               if (over) begin
                  conf_next = conf_inc;
                  if (conf_inc == CONFIRM_N8) begin
                     state_next = S_FIRE;
                  end
               end else begin
                  conf_next  = 8'd0;
                  state_next = S_IDLE;
               end
            end
         end
         S_FIRE: begin
            conf_next  = 8'd0;
            state_next = S_ALARM;
         end
         S_ALARM: begin
            // A clear sample beats a simultaneous repeat expiry.
            if (bus.temp_valid && clear) begin
               hold_load  = 1'b1;
               state_next = S_HOLDOFF;
            end else if (rep_done) begin
               state_next = S_FIRE;
            end
         end
         S_HOLDOFF: begin
            if (hold_done) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            conf_next  = 8'd0;
            state_next = S_IDLE;
         end
      endcase
   end

   // State, confirm count and pulse count; the pulse count steps as FIRE is entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         conf_cnt     <= 8'd0;
         fire_count_r <= 8'd0;
      end else begin
         state    <= state_next;
         conf_cnt <= conf_next;
         if (state_next == S_FIRE) begin
            fire_count_r <= sat_inc8(fire_count_r);
         end
      end
   end

   ms_timer #(
      .CYC_W (HOLD_W)
   ) u_holdoff (
      .clk      (clk),
      .reset    (reset),
      .load     (hold_load),
      .load_val (HOLD_W'(HOLDOFF_CYC)),
      .en       (state == S_HOLDOFF),
      .done     (hold_done)
   );

`ifdef ALARM_REPEAT_EN
   // The FIRE cycle itself is one cycle of the repeat period, so the
   // timer covers the remaining REPEAT_CYC-1 ALARM cycles.
   localparam int REP_W = $clog2(REPEAT_CYC);

   ms_timer #(
      .CYC_W (REP_W)
   ) u_repeat (
      .clk      (clk),
      .reset    (reset),
      .load     (state == S_FIRE),
      .load_val (REP_W'(REPEAT_CYC - 64'd1)),
      .en       (state == S_ALARM),
      .done     (rep_done)
   );
`else
   logic unused_repeat;

   assign rep_done      = 1'b0;
   assign unused_repeat = (REPEAT_CYC != 64'd0);
`endif

   assign bus.control      = (state == S_FIRE);
   assign bus.alarm_active = (state == S_FIRE) || (state == S_ALARM);
   assign bus.fire_count   = fire_count_r;

endmodule

// File: tb/tb_temp_alarm_trigger.sv
// Directed bench for temp_alarm_trigger: each step drives one cycle of
// stimulus, queues the outputs expected after the next clock edge and
// checks them against the DUT once that edge has passed.
module tb_temp_alarm_trigger;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   typedef struct {
      logic       c;
      logic       a;
      logic [7:0] f;
      string      tag;
   } exp_t;

   exp_t sb[$];

   temp_alarm_trigger_if #(.TEMP_W(13)) tif ();

   temp_alarm_trigger #(
      .SYS_FREQ   (1000),
      .TEMP_W     (13),
      .CONFIRM_N  (4),
      .HOLDOFF_MS (10),
      .REPEAT_MS  (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input logic c, input logic a, input int f, input string tag);
      exp_t e;
      e.c   = c;
      e.a   = a;
      e.f   = 8'(f);
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_sb();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      checks++;
      assert (tif.control === e.c) else begin
         failures++;
         $error("FAIL %s control observed=%0b expected=%0b", e.tag, tif.control, e.c);
      end
      checks++;
      assert (tif.alarm_active === e.a) else begin
         failures++;
         $error("FAIL %s alarm_active observed=%0b expected=%0b", e.tag, tif.alarm_active, e.a);
      end
      checks++;
      assert (tif.fire_count === e.f) else begin
         failures++;
         $error("FAIL %s fire_count observed=%0d expected=%0d", e.tag, tif.fire_count, e.f);
      end
   endtask

   // Drive one cycle, then check the outputs after the capturing edge.
   task automatic cyc(input logic v, input int d, input logic ec, input logic ea,
                      input int ef, input string tag);
      tif.temp_valid = v;
      tif.temp_data  = 13'(d);
      push_exp(ec, ea, ef, tag);
      @(posedge clk);
      #1;
      tif.temp_valid = 1'b0;
      check_sb();
   endtask

   task automatic idle(input int n, input logic ea, input int ef, input string tag);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 0, 1'b0, ea, ef, tag);
      end
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b1;
      tif.temp_valid = 1'b0;
      tif.temp_data  = 13'sd0;
      tif.thresh_hi  = 13'sd400;
      tif.thresh_lo  = 13'sd384;
      repeat (3) @(posedge clk);
      #1;
      push_exp(1'b0, 1'b0, 0, "reset_state");
      check_sb();
      reset = 1'b0;

      // Four samples of 410 spaced three cycles apart fire on the 4th.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 410, (i == 3), (i == 3), (i == 3) ? 1 : 0, "first_fire");
         if (i < 3) idle(2, 1'b0, 0, "confirm_gap");
      end
      idle(2, 1'b1, 1, "alarm_hold");

      // Band sample holds the alarm, clear sample starts a 10-cycle holdoff.
      cyc(1'b1, 390, 1'b0, 1'b1, 1, "band_keeps_alarm");
      cyc(1'b1, 380, 1'b0, 1'b0, 1, "clear_to_holdoff");
      idle(2, 1'b0, 1, "holdoff");
      cyc(1'b1, 410, 1'b0, 1'b0, 1, "holdoff_ignore");
      idle(6, 1'b0, 1, "holdoff");
      cyc(1'b1, 410, 1'b0, 1'b0, 1, "holdoff_last_cycle");
      for (int i = 0; i < 3; i++) cyc(1'b1, 410, 1'b0, 1'b0, 1, "rearm_confirm");
      cyc(1'b1, 410, 1'b1, 1'b1, 2, "second_fire");
      cyc(1'b0, 0, 1'b0, 1'b1, 2, "after_second");

      // Inverted band: clear falls back to below thresh_hi.
      tif.thresh_lo = 13'sd420;
      cyc(1'b1, 400, 1'b0, 1'b1, 2, "misconf_at_hi");
      cyc(1'b1, 399, 1'b0, 1'b0, 2, "misconf_clear");
      tif.thresh_lo = 13'sd384;
      idle(10, 1'b0, 2, "misconf_holdoff");

      // A dip below thresh_hi restarts confirmation; equality counts as over.
      for (int i = 0; i < 3; i++) cyc(1'b1, 410, 1'b0, 1'b0, 2, "pre_dip");
      cyc(1'b1, 395, 1'b0, 1'b0, 2, "dip");
      for (int i = 0; i < 3; i++) cyc(1'b1, 410, 1'b0, 1'b0, 2, "restart");
      cyc(1'b1, 400, 1'b1, 1'b1, 3, "fire_at_hi_equal");
      cyc(1'b1, 385, 1'b0, 1'b1, 3, "above_lo");
      cyc(1'b1, 384, 1'b0, 1'b0, 3, "clear_at_lo");
      idle(10, 1'b0, 3, "lo_holdoff");

      // Mid-cycle reset while alarmed clears everything without a clock edge.
      for (int i = 0; i < 3; i++) cyc(1'b1, 410, 1'b0, 1'b0, 3, "pre_reset_confirm");
      cyc(1'b1, 410, 1'b1, 1'b1, 4, "fourth_fire");
      #3;
      reset = 1'b1;
      #1;
      push_exp(1'b0, 1'b0, 0, "async_reset_alarm");
      check_sb();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset mid-confirm: counting restarts from one afterwards.
      for (int i = 0; i < 2; i++) cyc(1'b1, 410, 1'b0, 1'b0, 0, "partial_confirm");
      #3;
      reset = 1'b1;
      #1;
      push_exp(1'b0, 1'b0, 0, "async_reset_confirm");
      check_sb();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 410, 1'b0, 1'b0, 0, "post_reset_count");
      cyc(1'b1, 410, 1'b1, 1'b1, 1, "post_reset_fire");

`ifdef ALARM_REPEAT_EN
      for (int i = 0; i < 4; i++) cyc(1'b1, 410, 1'b0, 1'b1, 1, "repeat_wait");
      cyc(1'b1, 410, 1'b1, 1'b1, 2, "repeat_fire");
      for (int i = 0; i < 4; i++) cyc(1'b1, 410, 1'b0, 1'b1, 2, "repeat_wait2");
      cyc(1'b1, 380, 1'b0, 1'b0, 2, "clear_wins_expiry");
      idle(3, 1'b0, 2, "repeat_holdoff");
`else
      for (int i = 0; i < 10; i++) cyc(1'b1, 410, 1'b0, 1'b1, 1, "no_repeat");
      cyc(1'b1, 380, 1'b0, 1'b0, 1, "clear_no_repeat");
      idle(3, 1'b0, 1, "final_holdoff");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
